display_scan_ctrl: RTL

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl_if.sv | 31 +++
 rtl/display_scan_ctrl.sv | 95 +++++++++
 2 files changed

// File: rtl/display_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl_if
// Bundles the frame inputs and the scan outputs of display_scan_ctrl.
//   digitos        : four BCD digits, [3:0] = position 0 (right)
//   en_digitos     : per-position display enable
//   refrescamiento : current scan position 0..3
//   anodo          : active-low anode drive, bit i = position i
//   digito         : code for the active position, 4'hF = blank
//   tick           : one-cycle pulse after each slot boundary
//   frame          : one-cycle pulse when a new frame is latched
// master: the side supplying digits (system / bench); slave: the controller.
// -----------------------------------------------------------------------------
interface display_scan_ctrl_if;
   logic [15:0] digitos;
   logic [3:0]  en_digitos;
   logic [1:0]  refrescamiento;
   logic [3:0]  anodo;
   logic [3:0]  digito;
   logic        tick;
   logic        frame;

   modport master (
      output digitos, en_digitos,
      input  refrescamiento, anodo, digito, tick, frame
   );

   modport slave (
      input  digitos, en_digitos,
      output refrescamiento, anodo, digito, tick, frame
   );
endinterface

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Time-multiplexed 4-digit display scanner. A prescaler divides clk into digit
// slots of DIV cycles; each slot drives one position, opening with GUARD
// cycles of all anodes off. Digits and enables are latched once per frame
// (on the 3 -> 0 position wrap) so a frame never tears.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : display_scan_ctrl_if.slave (digitos, en_digitos in; scan outputs)
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
   parameter int unsigned DIV   = 100000,
   parameter int unsigned GUARD = 1000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   display_scan_ctrl_if.slave   bus
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    ref_q, ref_d;
   logic          tick_q, tick_d;
   logic          frame_q, frame_d;
   logic [15:0]   dig_q, dig_d;
   logic [3:0]    en_q, en_d;
   logic [3:0]    anodo_q, anodo_d;
   logic [3:0]    digito_q, digito_d;

   logic          wrap;
   logic          in_guard;

   assign wrap = (cnt_q == CW'(DIV - 1));

   // A zero guard would leave an always-false unsigned compare.
   generate
      if (GUARD == 0) begin : g_no_guard
         assign in_guard = 1'b0;
      end else begin : g_guard
         assign in_guard = (cnt_q < CW'(GUARD));
      end
   endgenerate

   always_comb begin
      cnt_d    = wrap ? '0 : cnt_q + 1'b1;
      ref_d    = ref_q + {1'b0, wrap};
      tick_d   = wrap;
      frame_d  = wrap && (ref_q == 2'd3);
      dig_d    = dig_q;
      en_d     = en_q;
      if (frame_d) begin
         dig_d = bus.digitos;
         en_d  = bus.en_digitos;
      end

      // Outputs are decoded from this cycle's state and appear one cycle later.
      anodo_d  = '1;
      digito_d = '1;
      if (!in_guard && en_q[ref_q]) begin
         anodo_d  = ~(4'b0001 << ref_q);
         digito_d = dig_q[{ref_q, 2'b00} +: 4];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         ref_q    <= '0;
         tick_q   <= 1'b0;
         frame_q  <= 1'b0;
         dig_q    <= '1;
         en_q     <= '0;
         anodo_q  <= '1;
         digito_q <= '1;
      end else begin
         cnt_q    <= cnt_d;
         ref_q    <= ref_d;
         tick_q   <= tick_d;
         frame_q  <= frame_d;
         dig_q    <= dig_d;
         en_q     <= en_d;
         anodo_q  <= anodo_d;
         digito_q <= digito_d;
      end
   end

   assign bus.refrescamiento = ref_q;
   assign bus.anodo          = anodo_q;
   assign bus.digito         = digito_q;
   assign bus.tick           = tick_q;
   assign bus.frame          = frame_q;

endmodule
